// File: rtl/rs232_avm_slave.sv
// Avalon-MM UART slave: RXDATA(0) / TXDATA(4) / STATUS(8) registers bridged to 8N1 serial lines.
// Every bus request is answered with exactly one wait cycle; side effects commit at the request edge.
module rs232_avm_slave #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   input  logic [4:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic        avs_waitrequest,
   input  logic        uart_rxd,
   output logic        uart_txd
);

   localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic {BUS_IDLE, BUS_RESP} bus_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   bus_state_t       r_bus_state, w_bus_next;
   rx_state_t        r_rx_state, w_rx_next;
   tx_state_t        r_tx_state, w_tx_next;

   logic [31:0]      r_readdata, w_rdata, w_status;
   logic             w_commit, w_rd_commit, w_wr_commit, w_rx_rd, w_tx_wr;

   logic [1:0]       r_rx_sync;
   logic             r_rx_prev, w_rx;
   logic [CNT_W-1:0] r_rx_cnt;
   logic [2:0]       r_rx_bit;
   logic [7:0]       r_rx_shift, r_rx_byte;
   logic             r_rx_full, r_overrun, r_frame_err;
   logic             w_rx_tick, w_rx_done, w_rx_ferr;

   logic [CNT_W-1:0] r_tx_cnt;
   logic [2:0]       r_tx_bit;
   logic [7:0]       r_tx_shift;
   logic             r_txd, w_trdy, w_tx_tick;
   logic             w_unused;

   assign w_unused = ^avs_writedata[31:8];

   // ---------------- bus FSM ----------------
   // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) r_bus_state <= BUS_IDLE;
      else         r_bus_state <= w_bus_next;
   end

   // NOTE: every always_comb assigns its outputs a default first, so no latch is inferred.
   always_comb begin
      w_bus_next = r_bus_state;
      case (r_bus_state)
         BUS_IDLE: if (avs_read || avs_write) w_bus_next = BUS_RESP;
         BUS_RESP: w_bus_next = BUS_IDLE;
         default:  w_bus_next = BUS_IDLE;
      endcase
   end

   always_comb begin
      avs_waitrequest = (r_bus_state != BUS_RESP);
   end

   assign w_commit    = (r_bus_state == BUS_IDLE) && (avs_read || avs_write);
   assign w_wr_commit = w_commit && avs_write;
   assign w_rd_commit = w_commit && avs_read && !avs_write;
   assign w_rx_rd     = w_rd_commit && (avs_address == 5'd0);
   assign w_tx_wr     = w_wr_commit && (avs_address == 5'd4) && w_trdy;
   assign w_status    = {24'b0, r_rx_full, w_trdy, 2'b0, r_overrun, r_frame_err, 2'b0};

   always_comb begin
      w_rdata = 32'b0;
      if (w_rd_commit) begin
         case (avs_address)
            5'd0:    w_rdata = {24'b0, r_rx_byte};
            5'd8:    w_rdata = w_status;
            default: w_rdata = 32'b0;
         endcase
      end
   end

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst)       r_readdata <= 32'b0;
      else if (w_commit) r_readdata <= w_rdata;
   end

   assign avs_readdata = r_readdata;

   // ---------------- RX path ----------------
   assign w_rx = r_rx_sync[1];

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) r_rx_state <= RX_IDLE;
      else         r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (r_rx_prev && !w_rx) w_rx_next = RX_START;
         RX_START: if (w_rx_tick) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      w_rx_tick = 1'b0;
      case (r_rx_state)
         RX_START:         w_rx_tick = (r_rx_cnt == HALF_END);
         RX_DATA, RX_STOP: w_rx_tick = (r_rx_cnt == BIT_END);
         default:          w_rx_tick = 1'b0;
      endcase
   end

   assign w_rx_done = w_rx_tick && (r_rx_state == RX_STOP) && w_rx;
   assign w_rx_ferr = w_rx_tick && (r_rx_state == RX_STOP) && !w_rx;

   // NOTE: only control/status flops need reset; the bus sees nothing of the shift registers until loaded.
   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         r_rx_sync   <= 2'b11;
         r_rx_prev   <= 1'b1;
         r_rx_cnt    <= '0;
         r_rx_bit    <= 3'd0;
         r_rx_shift  <= 8'd0;
         r_rx_byte   <= 8'd0;
         r_rx_full   <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_sync <= {r_rx_sync[0], uart_rxd};
         r_rx_prev <= w_rx;
         r_rx_cnt  <= (w_rx_tick || r_rx_state == RX_IDLE) ? '0 : r_rx_cnt + CNT_W'(1);
         if (r_rx_state != RX_DATA) r_rx_bit <= 3'd0;
         else if (w_rx_tick)        r_rx_bit <= r_rx_bit + 3'd1;
         if (w_rx_tick && r_rx_state == RX_DATA) r_rx_shift <= {w_rx, r_rx_shift[7:1]};
         // A read clears the flags; a delivery on the same edge then wins and reasserts rx_full.
         if (w_rx_rd) begin
            r_rx_full   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
         end
         if (w_rx_done) begin
            r_rx_byte <= r_rx_shift;
            r_rx_full <= 1'b1;
            if (r_rx_full && !w_rx_rd) r_overrun <= 1'b1;
         end
         if (w_rx_ferr) r_frame_err <= 1'b1;
      end
   end

   // ---------------- TX path ----------------
   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) r_tx_state <= TX_IDLE;
      else         r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (w_tx_wr) w_tx_next = TX_START;
         TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
         TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
         TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
         default:  w_tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      w_trdy    = (r_tx_state == TX_IDLE);
      w_tx_tick = (r_tx_state != TX_IDLE) && (r_tx_cnt == BIT_END);
   end

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         r_tx_cnt   <= '0;
         r_tx_bit   <= 3'd0;
         r_tx_shift <= 8'd0;
         r_txd      <= 1'b1;
      end else begin
         r_tx_cnt <= (w_tx_tick || r_tx_state == TX_IDLE) ? '0 : r_tx_cnt + CNT_W'(1);
         if (w_tx_wr) begin
            r_tx_shift <= avs_writedata[7:0];
            r_tx_bit   <= 3'd0;
            r_txd      <= 1'b0;
         end else if (w_tx_tick) begin
            case (r_tx_state)
               TX_START: begin
                  r_txd      <= r_tx_shift[0];
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
               end
               TX_DATA: begin
                  r_tx_bit <= r_tx_bit + 3'd1;
                  if (r_tx_bit == 3'd7) begin
                     r_txd <= 1'b1;
                  end else begin
                     r_txd      <= r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  end
               end
               default: r_txd <= 1'b1;
            endcase
         end
      end
   end

   assign uart_txd = r_txd;

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Scoreboard bench for rs232_avm_slave: bus reads and serial TX frames are checked against a
// register-level model of the UART updated as stimulus is issued.
module tb_rs232_avm_slave;

   localparam int CLKS = 8;

   logic        avm_clk = 1'b0;
   logic        avm_rst = 1'b1;
   logic [4:0]  avs_address = 5'd0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic        uart_rxd = 1'b1;
   logic        uart_txd;

   rs232_avm_slave #(.CLKS_PER_BIT(CLKS)) dut (
      .avm_clk        (avm_clk),
      .avm_rst        (avm_rst),
      .avs_address    (avs_address),
      .avs_read       (avs_read),
      .avs_readdata   (avs_readdata),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_waitrequest(avs_waitrequest),
      .uart_rxd       (uart_rxd),
      .uart_txd       (uart_txd)
   );

   always #5 avm_clk = ~avm_clk;

   int cyc = 0;
   always @(posedge avm_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // Model of the register file: flags, last byte, and the edge at which the transmitter frees up.
   bit          m_full, m_ovr, m_ferr;
   logic [7:0]  m_byte;
   int          tx_end = -1000;
   logic [31:0] expq[$];
   logic [7:0]  txq[$];
   bit          tx_mon_en = 1'b0;
   logic [31:0] last_exp;
   int          rx_start_cyc;
   logic [9:0]  mon_fr;
   logic [7:0]  mon_e;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] m_status(input int c);
      return {24'b0, m_full, (c > tx_end), 2'b0, m_ovr, m_ferr, 2'b0};
   endfunction

   task automatic model_reset();
      m_full = 0; m_ovr = 0; m_ferr = 0; m_byte = 8'd0;
      tx_end = -1000;
      txq.delete();
      expq.delete();
   endtask

   // One bus transaction; the request commits at the edge after the driving negedge.
   task automatic bus_xfer(input bit rd, input bit wr, input logic [4:0] addr, input logic [7:0] wd);
      int c;
      logic [31:0] exp;
      bit ok;
      @(negedge avm_clk);
      c   = cyc + 1;
      exp = 32'd0;
      if (wr) begin
         if (addr == 5'd4 && c > tx_end) begin
            tx_end = c + 10 * CLKS;
            txq.push_back(wd);
         end
      end else if (rd) begin
         if (addr == 5'd0) begin
            exp = {24'b0, m_byte};
            m_full = 0; m_ovr = 0; m_ferr = 0;
         end else if (addr == 5'd8) begin
            exp = m_status(c);
         end
      end
      last_exp = exp;
      expq.push_back(exp);
      avs_address   = addr;
      avs_read      = rd;
      avs_write     = wr;
      avs_writedata = {24'($urandom), wd};
      ok = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge avm_clk);
         if (!avs_waitrequest) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("bus_timeout", avs_waitrequest, 0);
      avs_read  = 1'b0;
      avs_write = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      @(negedge avm_clk);
      rx_start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         uart_rxd = f[i];
         repeat (CLKS) @(negedge avm_clk);
      end
      uart_rxd = 1'b1;
      if (stop) begin
         if (m_full) m_ovr = 1;
         m_byte = b;
         m_full = 1;
      end else begin
         m_ferr = 1;
      end
   endtask

   // Bus response monitor.
   always @(negedge avm_clk) begin
      if (!avm_rst && !avs_waitrequest) begin
         if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: got 0x%0h with no response expected", avs_readdata);
         end else begin
            check("readdata", avs_readdata, expq.pop_front());
         end
      end
   end

   // Serial TX monitor: samples each bit near its centre.
   initial begin
      forever begin
         @(negedge avm_clk);
         if (tx_mon_en && !avm_rst && uart_txd === 1'b0) begin
            repeat (CLKS / 2 - 1) @(negedge avm_clk);
            mon_fr[0] = uart_txd;
            for (int i = 1; i < 10; i++) begin
               repeat (CLKS) @(negedge avm_clk);
               mon_fr[i] = uart_txd;
            end
            if (txq.size() == 0) begin
               n_checks++;
               $display("FAIL tx_unexpected: frame 0x%0h with no write accepted", mon_fr);
            end else begin
               mon_e = txq.pop_front();
               check("tx_frame", mon_fr, {1'b1, mon_e, 1'b0});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [79:0] cap, expv;
      logic [9:0]  pat;
      logic [5:0]  wp;
      logic [7:0]  b;
      int          c, g;

      model_reset();
      repeat (3) @(negedge avm_clk);
      check("rst_waitrequest", avs_waitrequest, 1);
      check("rst_readdata", avs_readdata, 0);
      check("rst_txd", uart_txd, 1);
      avm_rst = 1'b0;

      // Reset in the middle of a TX frame.
      bus_xfer(0, 1, 5'd4, 8'h00);
      repeat (20) @(negedge avm_clk);
      check("txd_mid_frame", uart_txd, 0);
      #2 avm_rst = 1'b1;
      #1;
      check("rst_txd_immediate", uart_txd, 1);
      check("rst_waitrequest_mid", avs_waitrequest, 1);
      @(negedge avm_clk);
      avm_rst = 1'b0;
      model_reset();
      bus_xfer(1, 0, 5'd8, 8'h00);
      tx_mon_en = 1'b1;

      // RX byte.
      send_frame(8'hA5, 1);
      bus_xfer(1, 0, 5'd8, 8'h00);
      bus_xfer(1, 0, 5'd0, 8'h00);
      bus_xfer(1, 0, 5'd8, 8'h00);

      // Short glitch on the RX line must be ignored.
      @(negedge avm_clk);
      uart_rxd = 1'b0;
      repeat (2) @(negedge avm_clk);
      uart_rxd = 1'b1;
      repeat (30) @(negedge avm_clk);
      bus_xfer(1, 0, 5'd8, 8'h00);

      // TX byte with cycle-accurate bit stream, polling TRDY across the completion edge.
      bus_xfer(0, 1, 5'd4, 8'h3C);
      pat = {1'b1, 8'h3C, 1'b0};
      fork
         begin
            for (int k = 0; k < 10 * CLKS; k++) begin
               cap[k]  = uart_txd;
               expv[k] = pat[k / CLKS];
               @(negedge avm_clk);
            end
            check("tx_bitstream", cap, expv);
         end
         begin
            g = 0;
            do begin
               bus_xfer(1, 0, 5'd8, 8'h00);
               g++;
            end while (!last_exp[6] && g < 100);
         end
      join

      // Overrun, then framing error.
      send_frame(8'h11, 1);
      send_frame(8'h22, 1);
      bus_xfer(1, 0, 5'd8, 8'h00);
      bus_xfer(1, 0, 5'd0, 8'h00);
      bus_xfer(1, 0, 5'd8, 8'h00);
      send_frame(8'($urandom), 0);
      bus_xfer(1, 0, 5'd8, 8'h00);
      bus_xfer(1, 0, 5'd0, 8'h00);
      bus_xfer(1, 0, 5'd8, 8'h00);

      // RX delivery on the same edge as an RXDATA read commit.
      send_frame(8'h33, 1);
      rx_start_cyc = -1000;
      fork
         send_frame(8'h5A, 1);
         begin
            g = 0;
            do begin
               @(negedge avm_clk);
               g++;
            end while (cyc != rx_start_cyc + 77 && g < 200);
            bus_xfer(1, 0, 5'd0, 8'h00);
         end
      join
      bus_xfer(1, 0, 5'd8, 8'h00);
      bus_xfer(1, 0, 5'd0, 8'h00);

      // Held read: waitrequest toggles, one completion every second cycle.
      @(negedge avm_clk);
      c = cyc + 1;
      expq.push_back(m_status(c));
      expq.push_back(m_status(c + 2));
      expq.push_back(m_status(c + 4));
      avs_address = 5'd8;
      avs_read    = 1'b1;
      wp[5] = avs_waitrequest;
      for (int i = 4; i >= 0; i--) begin
         @(negedge avm_clk);
         wp[i] = avs_waitrequest;
      end
      avs_read = 1'b0;
      check("hs_waitrequest_pattern", wp, 6'b101010);

      // Read+write acts as a write; write on the TX completion edge is dropped.
      bus_xfer(1, 1, 5'd4, 8'h55);
      while (cyc + 2 < tx_end) @(negedge avm_clk);
      bus_xfer(0, 1, 5'd4, 8'h66);
      bus_xfer(0, 1, 5'd4, 8'h67);
      bus_xfer(1, 0, 5'd12, 8'h00);
      bus_xfer(0, 1, 5'd12, 8'hAA);
      bus_xfer(0, 1, 5'd4, 8'h99);

      // Wrapper-style traffic: 96 bytes in, 31 bytes out.
      for (int n = 0; n < 96; n++) begin
         b = 8'($urandom);
         send_frame(b, 1);
         bus_xfer(1, 0, 5'd8, 8'h00);
         bus_xfer(1, 0, 5'd0, 8'h00);
      end
      for (int n = 0; n < 31; n++) begin
         g = 0;
         do begin
            bus_xfer(1, 0, 5'd8, 8'h00);
            g++;
         end while (!last_exp[6] && g < 200);
         bus_xfer(0, 1, 5'd4, 8'($urandom));
      end

      for (int i = 0; i < 4000; i++) begin
         if (txq.size() == 0) break;
         @(negedge avm_clk);
      end
      check("tx_drain", txq.size(), 0);
      repeat (100) @(negedge avm_clk);
      check("scoreboard_drain", expq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
